// File: rtl/fruit_dropper.sv
// Spawns a row of seven falling fruits at LFSR-chosen x positions, steps the row down
// every TICKS_PER_STEP frame ticks, and reports whether it was caught or missed.
module fruit_dropper #(
  parameter logic [6:0]  Y_BOTTOM       = 7'd119,
  parameter int          TICKS_PER_STEP = 4,
  parameter logic [6:0]  LANE_SPACING   = 7'd16,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic       hit,
  output logic [6:0] fruitx,
  output logic [6:0] fruitx2,
  output logic [6:0] fruitx3,
  output logic [6:0] fruitx4,
  output logic [6:0] fruitx5,
  output logic [6:0] fruitx6,
  output logic [6:0] fruitx7,
  output logic [6:0] fruity,
  output logic [2:0] colour,
  output logic       row_spawned,
  output logic       missed,
  output logic       caught
);

  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [7:0]  TICK_LAST = 8'(TICKS_PER_STEP - 1);
  localparam logic [2:0]  BLACK     = 3'b111;

  typedef enum logic [1:0] {IDLE, SPAWN, FALL, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d, lfsr_nx;
  logic [6:0]  x_q [7];
  logic [6:0]  x_d [7];
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic [7:0]  tick_q, tick_d;
  logic        spawned_q, spawned_d;
  logic        missed_q, missed_d;
  logic        caught_q, caught_d;

  assign lfsr_nx = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    tick_d    = tick_q;
    spawned_d = 1'b0;
    missed_d  = 1'b0;
    caught_d  = 1'b0;

    if (!enable) begin
      state_d  = IDLE;
      colour_d = BLACK;
    end else begin
      case (state_q)
        IDLE: begin
          colour_d = BLACK;
          state_d  = SPAWN;
        end
        SPAWN: begin
          lfsr_d = lfsr_nx;
          for (int k = 0; k < 7; k++) begin
            x_d[k] = lfsr_nx[6:0] + LANE_SPACING * 7'(k);
          end
          y_d       = 7'd0;
          // Black means "no row", so a spawned row never takes that colour.
          colour_d  = (lfsr_nx[9:7] == BLACK) ? 3'b000 : lfsr_nx[9:7];
          tick_d    = 8'd0;
          spawned_d = 1'b1;
          state_d   = FALL;
        end
        FALL: begin
          if (hit) begin
            caught_d = 1'b1;
            colour_d = BLACK;
            state_d  = CLEAR;
          end else if (frame_tick) begin
            if (tick_q == TICK_LAST) begin
              tick_d = 8'd0;
              if (y_q == Y_BOTTOM) begin
                missed_d = 1'b1;
                colour_d = BLACK;
                state_d  = SPAWN;
              end else begin
                y_d = y_q + 7'd1;
              end
            end else begin
              tick_d = tick_q + 8'd1;
            end
          end
        end
        CLEAR: begin
          // Wait out one frame so a lingering hit cannot count twice.
          colour_d = BLACK;
          if (frame_tick) state_d = SPAWN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      for (int k = 0; k < 7; k++) x_q[k] <= 7'd0;
      y_q       <= 7'd0;
      colour_q  <= BLACK;
      tick_q    <= 8'd0;
      spawned_q <= 1'b0;
      missed_q  <= 1'b0;
      caught_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      tick_q    <= tick_d;
      spawned_q <= spawned_d;
      missed_q  <= missed_d;
      caught_q  <= caught_d;
    end
  end

  assign fruitx      = x_q[0];
  assign fruitx2     = x_q[1];
  assign fruitx3     = x_q[2];
  assign fruitx4     = x_q[3];
  assign fruitx5     = x_q[4];
  assign fruitx6     = x_q[5];
  assign fruitx7     = x_q[6];
  assign fruity      = y_q;
  assign colour      = colour_q;
  assign row_spawned = spawned_q;
  assign missed      = missed_q;
  assign caught      = caught_q;

endmodule

// File: tb/tb_fruit_dropper.sv
// Bench for fruit_dropper: directed scenarios plus random traffic, every cycle checked
// against a tick-count based reference model.
module tb_fruit_dropper;
  localparam int T  = 4;
  localparam int YB = 119;
  localparam int P_IDLE = 0, P_SPAWN = 1, P_FALL = 2, P_CLEAR = 3;

  logic       clk = 1'b0;
  logic       reset, enable, frame_tick, hit;
  logic [6:0] fruitx, fruitx2, fruitx3, fruitx4, fruitx5, fruitx6, fruitx7, fruity;
  logic [2:0] colour;
  logic       row_spawned, missed, caught;

  always #5 clk = ~clk;

  fruit_dropper dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick), .hit(hit),
    .fruitx(fruitx), .fruitx2(fruitx2), .fruitx3(fruitx3), .fruitx4(fruitx4),
    .fruitx5(fruitx5), .fruitx6(fruitx6), .fruitx7(fruitx7), .fruity(fruity),
    .colour(colour), .row_spawned(row_spawned), .missed(missed), .caught(caught)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: row position derived from ticks elapsed since the spawn.
  int m_phase, m_nspawn, m_ticks, m_y, m_col;
  int m_x [7];
  bit m_sp, m_mi, m_ca;

  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < n; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    return l;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit f, input bit h);
    logic [15:0] v;
    m_sp = 0; m_mi = 0; m_ca = 0;
    if (r) begin
      m_phase = P_IDLE; m_nspawn = 0; m_ticks = 0; m_y = 0; m_col = 7;
      for (int k = 0; k < 7; k++) m_x[k] = 0;
    end else if (!e) begin
      m_phase = P_IDLE; m_col = 7;
    end else begin
      case (m_phase)
        P_IDLE: m_phase = P_SPAWN;
        P_SPAWN: begin
          m_nspawn++;
          v = lfsr_after(m_nspawn);
          for (int k = 0; k < 7; k++) m_x[k] = (int'(v[6:0]) + 16 * k) % 128;
          m_col   = (v[9:7] == 3'b111) ? 0 : int'(v[9:7]);
          m_y     = 0;
          m_ticks = 0;
          m_sp    = 1;
          m_phase = P_FALL;
        end
        P_FALL: begin
          if (h) begin
            m_ca = 1; m_col = 7; m_phase = P_CLEAR;
          end else if (f) begin
            m_ticks++;
            if (m_ticks == (YB + 1) * T) begin
              m_mi = 1; m_col = 7; m_phase = P_SPAWN;
            end else begin
              m_y = m_ticks / T;
            end
          end
        end
        default: if (f) m_phase = P_SPAWN;
      endcase
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit f, input bit h);
    reset = r; enable = e; frame_tick = f; hit = h;
    model_step(r, e, f, h);
    @(posedge clk);
    #1;
    chk("x0", fruitx,  m_x[0]);
    chk("x1", fruitx2, m_x[1]);
    chk("x2", fruitx3, m_x[2]);
    chk("x3", fruitx4, m_x[3]);
    chk("x4", fruitx5, m_x[4]);
    chk("x5", fruitx6, m_x[5]);
    chk("x6", fruitx7, m_x[6]);
    chk("y", fruity, m_y);
    chk("colour", colour, m_col);
    chk("row_spawned", row_spawned, m_sp);
    chk("missed", missed, m_mi);
    chk("caught", caught, m_ca);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 1, 0);
      cyc(0, 1, 0, 0);
    end
  endtask

  initial begin
    reset = 1; enable = 0; frame_tick = 0; hit = 0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_colour", colour, 3'b111);
    chk("rst_x0", fruitx, 0);

    // First spawn from the reset seed
    cyc(0, 1, 0, 0);
    chk("pre_spawn", row_spawned, 0);
    cyc(0, 1, 0, 0);
    chk("spawn_pulse", row_spawned, 1);
    chk("spawn_x0", fruitx, 67);
    chk("spawn_x4", fruitx5, 3);
    chk("spawn_x6", fruitx7, 35);
    chk("spawn_col", colour, 3'b011);

    // Step cadence
    ticks(8);  chk("y_after8", fruity, 2);
    ticks(3);  chk("y_after11", fruity, 2);
    ticks(1);  chk("y_after12", fruity, 3);

    // Fall to the bottom: miss on tick 480
    ticks(467);
    chk("y_bottom", fruity, 119);
    cyc(0, 1, 1, 0);
    chk("miss_pulse", missed, 1);
    chk("miss_y", fruity, 119);
    chk("miss_col", colour, 3'b111);
    cyc(0, 1, 0, 0);
    chk("respawn_pulse", row_spawned, 1);
    chk("respawn_y", fruity, 0);
    chk("respawn_x0", fruitx, int'(lfsr_after(2) & 16'h007F));

    // Catch at y=10, repeat hit ignored, next frame respawns
    ticks(40);
    chk("y10", fruity, 10);
    cyc(0, 1, 0, 1);
    chk("catch_pulse", caught, 1);
    chk("catch_col", colour, 3'b111);
    chk("catch_y", fruity, 10);
    cyc(0, 1, 0, 1);
    chk("stale_hit", caught, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    chk("after_clear_spawn", row_spawned, 1);

    // Hit coincides with the bottom step
    ticks(479);
    cyc(0, 1, 1, 1);
    chk("bottom_hit_caught", caught, 1);
    chk("bottom_hit_missed", missed, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);

    // Disable mid-fall, resume, then reset mid-fall
    ticks(6);
    cyc(0, 0, 0, 0);
    chk("disable_col", colour, 3'b111);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("resume_spawn", row_spawned, 1);
    ticks(5);
    cyc(1, 1, 1, 1);
    chk("rst2_y", fruity, 0);
    chk("rst2_col", colour, 3'b111);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("reseed_x0", fruitx, 67);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 999) == 0, $urandom_range(0, 49) != 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fruit_dropper.md
Name: fruit_dropper

Overview:
- Upstream stage of the hit detector. Spawns a row of seven falling fruits at pseudo-random x positions with a random colour, then steps the row downward once every TICKS_PER_STEP frame ticks.
- Clears the row on a registered hit from the hit detector, and flags a miss when the row reaches the bottom.
- Drives the hit detector's fruitx..fruitx7, fruity and colour inputs directly.

Parameters:
- Y_BOTTOM, 7'd119: last row index; a step taken at this row is a miss.
- TICKS_PER_STEP, 4: frame_tick pulses per one-row descent; legal range 1..255.
- LANE_SPACING, 7'd16: x distance between adjacent fruits in a row.
- LFSR_SEED, 16'hACE1: reset value of the LFSR; a value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  game running; low forces IDLE
- frame_tick  in  1  one-cycle pulse per video frame
- hit  in  1  registered hit flag from the hit detector
- fruitx  out  7  lane 0 x
- fruitx2  out  7  lane 1 x
- fruitx3  out  7  lane 2 x
- fruitx4  out  7  lane 3 x
- fruitx5  out  7  lane 4 x
- fruitx6  out  7  lane 5 x
- fruitx7  out  7  lane 6 x
- fruity  out  7  shared row y
- colour  out  3  row colour; 3'b111 = no live row (black)
- row_spawned  out  1  one-cycle pulse when a new row is loaded
- missed  out  1  one-cycle pulse when a row falls off the bottom
- caught  out  1  one-cycle pulse when a hit clears the row

Behaviour:
- All outputs are registered.
- Reset state:
  - state = IDLE, lfsr = LFSR_SEED, tick_cnt = 0.
  - All x outputs = 0, fruity = 0, colour = 3'b111.
  - All pulse outputs = 0.
  - Reset wins over every other input.
- LFSR:
  - 16-bit Fibonacci; fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
  - Shifts only in the SPAWN state, exactly once per spawn.
- IDLE:
  - colour = 3'b111; x and y outputs hold their values.
  - enable = 1 -> SPAWN on the next cycle.
- SPAWN (one cycle):
  - lfsr <= next.
  - Compute from next: base = next[6:0]; lane k x = base + k*LANE_SPACING, k = 0..6, 7-bit wraparound (mod 128).
  - fruity <= 0; colour <= next[9:7], except 3'b111 is remapped to 3'b000 so a spawned row is always visible.
  - tick_cnt <= 0; row_spawned = 1 for this cycle.
  - -> FALL.
- FALL:
  - Each frame_tick increments tick_cnt.
  - When frame_tick arrives with tick_cnt == TICKS_PER_STEP-1: tick_cnt <= 0 (a "step").
    - If fruity != Y_BOTTOM: fruity <= fruity+1.
    - If fruity == Y_BOTTOM: missed = 1, colour <= 3'b111, -> SPAWN next cycle (fruity is not incremented).
  - hit = 1 in FALL: caught = 1, colour <= 3'b111, -> CLEAR.
  - hit and a bottom step in the same cycle: the hit wins; caught = 1, missed = 0.
  - hit and a non-bottom step in the same cycle: the hit wins and fruity is not incremented.
- CLEAR:
  - colour = 3'b111, outputs held.
  - Next frame_tick -> SPAWN. This gives a one-frame gap and stops a stale hit from double-counting.
- hit is ignored in IDLE, SPAWN and CLEAR.
- enable = 0 in any state:
  - -> IDLE next cycle, colour <= 3'b111, no pulses.
  - lfsr is retained, so play resumes with a new row.
- Pulses never assert together, and none asserts in the same cycle as reset.

Test Plan:
- Reset, then enable = 1 with defaults -> one cycle later row_spawned = 1; lfsr = 16'h59C3; x = 67, 83, 99, 115, 3, 19, 35; fruity = 0; colour = 3'b011.
- After the first spawn, apply frame_tick 8 times -> fruity = 2; 3 more ticks -> still 2; 1 more -> 3.
- Let the row fall with no hit, 480 ticks total -> missed pulses once on the 480th tick with fruity = 119; next cycle row_spawned = 1, fruity = 0, new x values from the next LFSR step.
- Assert hit while fruity = 10 in FALL -> caught = 1 and colour = 3'b111 next cycle; fruity stays 10; further hits ignored; next frame_tick -> SPAWN.
- Assert hit in the same cycle as the bottom step (fruity = 119, tick_cnt = 3, frame_tick) -> caught = 1, missed = 0.
- Drop enable mid-FALL -> IDLE, colour = 3'b111. Then assert reset mid-FALL -> all outputs return to reset values and lfsr returns to 16'hACE1.
